mm_txn_monitor: RTL and testbench
=================================

MM_TXN_MONITOR -- requirements
Module: mm_txn_monitor

Interface
REQ-001 Parameter ADDR_W, default 32: address width of the monitored memory-mapped bus.
REQ-002 Parameter DATA_W, default 32: read/write data width.
REQ-003 Parameter MAX_PENDING, default 8, legal range 2..64: depth of the outstanding-read tracker.
REQ-004 Parameter TIMEOUT, default 256, legal range >=2: cycles an oldest pending read may wait before error.
REQ-005 Parameter CNT_W, default 16: width of the transaction counters.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 mm_address  input  ADDR_W  monitored request address.
REQ-009 mm_read  input  1  read request.
REQ-010 mm_write  input  1  write request.
REQ-011 mm_waitrequest  input  1  slave stall; a request is accepted only when this is low.
REQ-012 mm_readdata  input  DATA_W  returned read data.
REQ-013 mm_readdatavalid  input  1  read response strobe, one per accepted read, in order.
REQ-014 err_clear  input  1  synchronous clear of all sticky error flags.
REQ-015 rsp_valid  output  1  one-cycle pulse: matched read response available.
REQ-016 rsp_addr  output  ADDR_W  address of the read request matched to this response.
REQ-017 rsp_data  output  DATA_W  data of the matched response.
REQ-018 pending  output  $clog2(MAX_PENDING+1)  outstanding accepted reads.
REQ-019 rd_count, wr_count  output  CNT_W each  accepted read / write totals.
REQ-020 err_overflow, err_unexpected, err_timeout, err_rw_conflict  output  1 each  sticky error flags.
REQ-021 err_any  output  1  OR of the four error flags.

Function
REQ-022 rd_acc = mm_read & ~mm_write & ~mm_waitrequest; wr_acc = mm_write & ~mm_read & ~mm_waitrequest.
REQ-023 mm_read & mm_write in the same cycle (any waitrequest) shall set err_rw_conflict; neither is counted or recorded.
REQ-024 rd_acc shall push mm_address into an in-order FIFO of depth MAX_PENDING; mm_readdatavalid shall pop it.
REQ-025 rsp_valid shall assert exactly 1 cycle after a successful pop, with rsp_addr = popped address and rsp_data = mm_readdata registered in the same cycle; rsp_addr/rsp_data hold their value otherwise.
REQ-026 Push and pop in the same cycle with pending>0: both proceed, pending unchanged, including when pending==MAX_PENDING.
REQ-027 rd_acc with pending==MAX_PENDING and no pop: err_overflow set, address discarded, pending unchanged, rd_count still increments.
REQ-028 mm_readdatavalid with pending==0: err_unexpected set, no rsp_valid; a push in that same cycle still proceeds (zero-latency responses are illegal).
REQ-029 An age counter tracks the oldest entry: cleared on every pop and on pending 0->1; increments each cycle while pending>0; saturates at TIMEOUT.
REQ-030 Age reaching TIMEOUT shall set err_timeout in the cycle the counter reaches TIMEOUT; no entry is dropped.
REQ-031 rd_count/wr_count increment by 1 on rd_acc/wr_acc, saturating at 2^CNT_W-1 (no wrap).
REQ-032 Error flags are sticky until err_clear; a new error event in the same cycle as err_clear wins (flag stays set).
REQ-033 err_any is combinational from the registered flags.

Reset
REQ-034 reset_n low shall asynchronously clear FIFO pointers, pending, age counter, rd_count, wr_count, all error flags, rsp_valid, rsp_addr, rsp_data to 0.
REQ-035 Reset mid-operation discards all outstanding reads; responses arriving after release with pending==0 set err_unexpected.
REQ-036 Outputs shall be valid (reset values) in the first cycle after reset_n rises; no request is accepted while reset_n is low.

Verification
REQ-037 Reads to 0x10,0x20,0x30 (waitrequest low), readdatavalid with 0xA,0xB,0xC 3 cycles later -> rsp pulses (0x10,0xA),(0x20,0xB),(0x30,0xC), pending 3->0, rd_count=3, no errors.
REQ-038 MAX_PENDING=8: 9 reads without responses -> err_overflow on 9th, pending=8, rd_count=9; then 8 responses return the first 8 addresses in order.
REQ-039 MAX_PENDING full, one read and one readdatavalid in the same cycle -> no error, pending stays 8, next response returns the new entry last.
REQ-040 One read, no response, TIMEOUT=256 -> err_timeout rises exactly 256 cycles after acceptance; err_clear in that cycle leaves it set; err_clear next cycle clears it.
REQ-041 readdatavalid with pending=0, then read+write together -> err_unexpected and err_rw_conflict set, err_any=1, counters unchanged; reset_n pulse mid-stream -> all outputs 0.
REQ-042 CNT_W=4: 20 writes -> wr_count stops at 15.

Source files
------------

// File: rtl/mm_txn_monitor.sv
// mm_txn_monitor: passive monitor for a memory-mapped bus that matches in-order read responses to their request addresses
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   mm_address/read/write     observed request (accepted when mm_waitrequest is low)
//   mm_readdata/readdatavalid observed in-order read response
//   err_clear                 synchronous clear of sticky error flags
//   rsp_valid/addr/data       one-cycle pulse with the matched request address and response data
//   pending                   outstanding accepted reads
//   rd_count, wr_count        saturating accepted read/write totals
//   err_*                     sticky error flags, err_any is their OR
module mm_txn_monitor #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 8,
    parameter int TIMEOUT     = 256,
    parameter int CNT_W       = 16,
    localparam int PW         = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] mm_address,
    input  logic              mm_read,
    input  logic              mm_write,
    input  logic              mm_waitrequest,
    input  logic [DATA_W-1:0] mm_readdata,
    input  logic              mm_readdatavalid,
    input  logic              err_clear,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic [PW-1:0]     pending,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_overflow,
    output logic              err_unexpected,
    output logic              err_timeout,
    output logic              err_rw_conflict,
    output logic              err_any
);
    localparam int AW = $clog2(MAX_PENDING);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [ADDR_W-1:0] mem [MAX_PENDING];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]     age, age_nxt;
    logic              rd_acc, wr_acc, full, pop, push, ovf, unexp, tmo, conflict;

    always_comb begin
        conflict = mm_read & mm_write;
        rd_acc   = mm_read & ~mm_write & ~mm_waitrequest;
        wr_acc   = mm_write & ~mm_read & ~mm_waitrequest;
        full     = pending == PW'(MAX_PENDING);
        pop      = mm_readdatavalid & (pending != '0);
        unexp    = mm_readdatavalid & (pending == '0);
        // a pop frees a slot in the same cycle, so a full tracker still accepts
        push     = rd_acc & (~full | pop);
        ovf      = rd_acc & full & ~pop;
        // age follows the oldest entry: restart on each pop and while empty
        age_nxt  = (pop | (pending == '0)) ? '0 : (age == TW'(TIMEOUT) ? age : age + 1'b1);
        // fire once on arrival at TIMEOUT, not on every saturated cycle
        tmo      = (age != TW'(TIMEOUT)) & (age_nxt == TW'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= mm_address;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            pending         <= '0;
            age             <= '0;
            rd_count        <= '0;
            wr_count        <= '0;
            rsp_valid       <= 1'b0;
            rsp_addr        <= '0;
            rsp_data        <= '0;
            err_overflow    <= 1'b0;
            err_unexpected  <= 1'b0;
            err_timeout     <= 1'b0;
            err_rw_conflict <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(MAX_PENDING - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= (rd_ptr == AW'(MAX_PENDING - 1)) ? '0 : rd_ptr + 1'b1;
                rsp_addr <= mem[rd_ptr];
                rsp_data <= mm_readdata;
            end
            rsp_valid       <= pop;
            pending         <= pending + PW'(push) - PW'(pop);
            age             <= age_nxt;
            if (rd_acc && rd_count != '1) rd_count <= rd_count + 1'b1;
            if (wr_acc && wr_count != '1) wr_count <= wr_count + 1'b1;
            err_overflow    <= ovf | (err_overflow & ~err_clear);
            err_unexpected  <= unexp | (err_unexpected & ~err_clear);
            err_timeout     <= tmo | (err_timeout & ~err_clear);
            err_rw_conflict <= conflict | (err_rw_conflict & ~err_clear);
        end
    end

    assign err_any = err_overflow | err_unexpected | err_timeout | err_rw_conflict;
endmodule

// File: tb/tb_mm_txn_monitor.sv
// tb_mm_txn_monitor: directed scoreboard bench for mm_txn_monitor
module tb_mm_txn_monitor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mm_address = '0;
    logic        mm_read = 1'b0;
    logic        mm_write = 1'b0;
    logic        mm_waitrequest = 1'b0;
    logic [31:0] mm_readdata = '0;
    logic        mm_readdatavalid = 1'b0;
    logic        err_clear = 1'b0;

    logic        rsp_valid;
    logic [31:0] rsp_addr, rsp_data;
    logic [3:0]  pending;
    logic [15:0] rd_count, wr_count;
    logic        err_overflow, err_unexpected, err_timeout, err_rw_conflict, err_any;

    logic        s_rsp_valid;
    logic [31:0] s_rsp_addr, s_rsp_data;
    logic [3:0]  s_pending;
    logic [3:0]  s_rd_count, s_wr_count;
    logic        s_ovf, s_unexp, s_tmo, s_rw, s_any;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    mm_txn_monitor u_dut (
        .clk(clk), .reset_n(reset_n), .mm_address(mm_address), .mm_read(mm_read),
        .mm_write(mm_write), .mm_waitrequest(mm_waitrequest), .mm_readdata(mm_readdata),
        .mm_readdatavalid(mm_readdatavalid), .err_clear(err_clear), .rsp_valid(rsp_valid),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .pending(pending), .rd_count(rd_count),
        .wr_count(wr_count), .err_overflow(err_overflow), .err_unexpected(err_unexpected),
        .err_timeout(err_timeout), .err_rw_conflict(err_rw_conflict), .err_any(err_any)
    );

    mm_txn_monitor #(.CNT_W(4)) u_small (
        .clk(clk), .reset_n(reset_n), .mm_address(mm_address), .mm_read(mm_read),
        .mm_write(mm_write), .mm_waitrequest(mm_waitrequest), .mm_readdata(mm_readdata),
        .mm_readdatavalid(mm_readdatavalid), .err_clear(err_clear), .rsp_valid(s_rsp_valid),
        .rsp_addr(s_rsp_addr), .rsp_data(s_rsp_data), .pending(s_pending), .rd_count(s_rd_count),
        .wr_count(s_wr_count), .err_overflow(s_ovf), .err_unexpected(s_unexp),
        .err_timeout(s_tmo), .err_rw_conflict(s_rw), .err_any(s_any)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_extra: got addr %0h data %0h expected no response", rsp_addr, rsp_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("rsp_addr", {32'h0, rsp_addr}, {32'h0, e[63:32]});
                check("rsp_data", {32'h0, rsp_data}, {32'h0, e[31:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        mm_read = 1'b1;
        mm_address = a;
        tick();
        mm_read = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        mm_readdatavalid = 1'b1;
        mm_readdata = d;
        tick();
        mm_readdatavalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tmo_early;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_pending", 64'(pending), 64'd0);
        check("reset_rd_count", 64'(rd_count), 64'd0);
        check("reset_err_any", 64'(err_any), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();

        // stalled read is not accepted
        mm_waitrequest = 1'b1;
        rd(32'h99);
        mm_waitrequest = 1'b0;
        check("stall_pending", 64'(pending), 64'd0);

        // three reads, responses a few cycles later
        rd(32'h10);
        rd(32'h20);
        rd(32'h30);
        check("basic_pending3", 64'(pending), 64'd3);
        tick();
        tick();
        rsp(32'h10, 32'hA);
        rsp(32'h20, 32'hB);
        rsp(32'h30, 32'hC);
        tick();
        check("basic_pending0", 64'(pending), 64'd0);
        check("basic_rd_count", 64'(rd_count), 64'd3);
        check("basic_err_any", 64'(err_any), 64'd0);

        // overflow on the ninth read
        for (int i = 0; i < 8; i++) rd(32'h100 + 32'(i) * 4);
        check("ovf_before", 64'(err_overflow), 64'd0);
        rd(32'h1FC);
        check("ovf_flag", 64'(err_overflow), 64'd1);
        check("ovf_pending", 64'(pending), 64'd8);
        check("ovf_rd_count", 64'(rd_count), 64'd12);
        for (int i = 0; i < 8; i++) rsp(32'h100 + 32'(i) * 4, 32'h200 + 32'(i));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("ovf_drain_pending", 64'(pending), 64'd0);
        check("ovf_cleared", 64'(err_any), 64'd0);

        // full tracker with simultaneous push and pop
        for (int i = 0; i < 8; i++) rd(32'h300 + 32'(i));
        exp_q.push_back({32'h300, 32'h50});
        mm_read = 1'b1;
        mm_address = 32'h3FF;
        mm_readdatavalid = 1'b1;
        mm_readdata = 32'h50;
        tick();
        mm_read = 1'b0;
        mm_readdatavalid = 1'b0;
        check("full_pp_pending", 64'(pending), 64'd8);
        check("full_pp_err", 64'(err_any), 64'd0);
        for (int i = 1; i < 8; i++) rsp(32'h300 + 32'(i), 32'h60 + 32'(i));
        rsp(32'h3FF, 32'h68);
        tick();
        check("full_pp_drain", 64'(pending), 64'd0);
        check("full_pp_rd_count", 64'(rd_count), 64'd21);

        // timeout exactly TIMEOUT cycles after acceptance
        rd(32'h400);
        tmo_early = 1'b0;
        for (int i = 1; i < 256; i++) begin
            if (i == 255) err_clear = 1'b1;
            tick();
            if (i < 255) tmo_early = tmo_early | err_timeout;
        end
        check("tmo_not_early", 64'(tmo_early | err_timeout), 64'd0);
        tick();
        check("tmo_set_wins_clear", 64'(err_timeout), 64'd1);
        tick();
        err_clear = 1'b0;
        check("tmo_cleared", 64'(err_timeout), 64'd0);
        rsp(32'h400, 32'h77);
        tick();
        check("tmo_drain", 64'(pending), 64'd0);
        check("tmo_rd_count", 64'(rd_count), 64'd22);

        // unexpected response and read/write conflict
        mm_readdatavalid = 1'b1;
        mm_readdata = 32'hDEAD;
        tick();
        mm_readdatavalid = 1'b0;
        check("unexp_flag", 64'(err_unexpected), 64'd1);
        mm_read = 1'b1;
        mm_write = 1'b1;
        mm_waitrequest = 1'b1;
        tick();
        mm_read = 1'b0;
        mm_write = 1'b0;
        mm_waitrequest = 1'b0;
        check("rw_flag", 64'(err_rw_conflict), 64'd1);
        check("rw_err_any", 64'(err_any), 64'd1);
        check("rw_rd_count", 64'(rd_count), 64'd22);
        check("rw_wr_count", 64'(wr_count), 64'd0);
        check("rw_pending", 64'(pending), 64'd0);

        // reset mid-stream discards outstanding reads
        rd(32'h500);
        rd(32'h504);
        check("pre_reset_pending", 64'(pending), 64'd2);
        reset_n = 1'b0;
        #2;
        check("async_pending", 64'(pending), 64'd0);
        check("async_err_any", 64'(err_any), 64'd0);
        check("async_rd_count", 64'(rd_count), 64'd0);
        check("async_rsp_addr", 64'(rsp_addr), 64'd0);
        check("async_rsp_data", 64'(rsp_data), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        mm_readdatavalid = 1'b1;
        mm_readdata = 32'h11;
        tick();
        mm_readdatavalid = 1'b0;
        check("post_reset_unexp", 64'(err_unexpected), 64'd1);
        check("post_reset_pending", 64'(pending), 64'd0);

        // write counter saturation on the narrow instance
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        mm_write = 1'b1;
        repeat (20) tick();
        mm_write = 1'b0;
        check("wr_count_wide", 64'(wr_count), 64'd20);
        check("wr_count_sat", 64'(s_wr_count), 64'd15);

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
